// File: rtl/div32_seq_if.sv
// Operand/result handshake bundle for the div32_seq sequential divider.
// SIGNED_DIV_EN adds the in_signed operand qualifier.
interface div32_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
`ifdef SIGNED_DIV_EN
    logic             in_signed;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_divzero;

    // Both channels: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable while valid=1 and ready=0.
`ifdef SIGNED_DIV_EN
    modport master (
        output in_valid, in_dividend, in_divisor, in_signed, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_divzero
    );
    modport slave (
        input  in_valid, in_dividend, in_divisor, in_signed, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_divzero
    );
`else
    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_divzero
    );
    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_divzero
    );
`endif
endinterface

// File: rtl/div32_seq.sv
// 32-bit restoring divider, one trial subtraction per clock, 32 iterations.
// Optional SIGNED_DIV_EN: truncating signed division via magnitude + sign fix-up.
module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    div32_seq_if.slave       bus,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem33, diff;
    logic [WIDTH-1:0] q_out, r_out;
    logic             z_out;
    logic             in_ready_c, out_valid_c;
    logic             last_iter, accept;
    logic [WIDTH-1:0] mag_n, mag_d, quo_fix, rem_fix;

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r;
    logic sn, sd;
    assign sn      = bus.in_signed & bus.in_dividend[WIDTH-1];
    assign sd      = bus.in_signed & bus.in_divisor[WIDTH-1];
    assign mag_n   = sn ? -bus.in_dividend : bus.in_dividend;
    assign mag_d   = sd ? -bus.in_divisor  : bus.in_divisor;
    assign quo_fix = neg_q ? -quo_nxt : quo_nxt;
    assign rem_fix = neg_r ? -rem_nxt : rem_nxt;
`else
    assign mag_n   = bus.in_dividend;
    assign mag_d   = bus.in_divisor;
    assign quo_fix = quo_nxt;
    assign rem_fix = rem_nxt;
`endif

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign accept    = bus.in_valid && in_ready_c;

    // One restoring step: shift next dividend bit in, keep the difference on no-borrow.
    always_comb begin
        rem33 = {rem, quo[WIDTH-1]};
        diff  = rem33 - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem33[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_nxt = (bus.in_divisor == '0) ? DONE : CALC;
            end
            CALC: if (last_iter) state_nxt = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_out <= '0;
            r_out <= '0;
            z_out <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (bus.in_divisor == '0) begin
                        // Divide-by-zero skips iteration; remainder is the raw dividend.
                        q_out <= '1;
                        r_out <= bus.in_dividend;
                        z_out <= 1'b1;
                    end else begin
                        rem   <= '0;
                        quo   <= mag_n;
                        dvs   <= mag_d;
                        cnt   <= '0;
                        z_out <= 1'b0;
`ifdef SIGNED_DIV_EN
                        neg_q <= sn ^ sd;
                        neg_r <= sn;
`endif
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (last_iter) begin
                        cnt   <= '0;
                        q_out <= quo_fix;
                        r_out <= rem_fix;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_quotient  = q_out;
    assign bus.out_remainder = r_out;
    assign bus.out_divzero   = z_out;
    assign state_dbg         = state;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed edge cases, backpressure, reset abort,
// and random operands against an arithmetic reference model.
module tb_div32_seq;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_pass;

    div32_seq_if #(.WIDTH(32)) bus ();

    div32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Reference: plain arithmetic from the division rules.
    task automatic ref_div(input logic [31:0] n, input logic [31:0] d, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        int a, b;
        z = 1'b0;
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = n;
            z = 1'b1;
        end else if (!sgn) begin
            q = n / d;
            r = n % d;
        end else if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            a = n;
            b = d;
            q = a / b;
            r = a % b;
        end
    endtask

    // Entered and left on a falling edge with out_ready=1.
    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input logic sgn,
                          input string tag);
        logic [31:0] eq, er;
        logic        ez;
        int          lat;
        ref_div(n, d, sgn, eq, er, ez);
        check1({tag, ".in_ready_before"}, bus.in_ready, 1'b1);
        bus.in_valid    = 1'b1;
        bus.in_dividend = n;
        bus.in_divisor  = d;
`ifdef SIGNED_DIV_EN
        bus.in_signed   = sgn;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.in_dividend = $urandom;
        bus.in_divisor  = $urandom;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check32({tag, ".latency"}, 32'(lat), (d == 32'd0) ? 32'd1 : 32'd33);
        check32({tag, ".quotient"}, bus.out_quotient, eq);
        check32({tag, ".remainder"}, bus.out_remainder, er);
        check1({tag, ".divzero"}, bus.out_divzero, ez);
        @(negedge clk);
        check1({tag, ".out_valid_after"}, bus.out_valid, 1'b0);
        check1({tag, ".in_ready_after"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] eq, er, rn, rd;
        logic        ez;
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b1;
`ifdef SIGNED_DIV_EN
        bus.in_signed   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check1("reset.in_ready", bus.in_ready, 1'b1);
        check1("reset.out_valid", bus.out_valid, 1'b0);
        check32("reset.quotient", bus.out_quotient, 32'd0);
        check32("reset.remainder", bus.out_remainder, 32'd0);
        check1("reset.divzero", bus.out_divzero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, "d100_7");
        run_op(32'h0000_1234, 32'd0, 1'b0, "div0");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "max_1");
        run_op(32'd5, 32'd9, 1'b0, "n_lt_d");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "n_eq_d");
        run_op(32'd0, 32'd13, 1'b0, "zero_n");
        run_op(32'h8000_0000, 32'h8000_0001, 1'b0, "big_lt");

        // Backpressure: result must hold and in_valid must be ignored while in DONE.
        bus.out_ready = 1'b0;
        ref_div(32'd1000, 32'd3, 1'b0, eq, er, ez);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 32'd1000;
        bus.in_divisor  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (40) begin
            if (bus.out_valid !== 1'b1) @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            check1("hold.out_valid", bus.out_valid, 1'b1);
            check1("hold.in_ready", bus.in_ready, 1'b0);
            check32("hold.quotient", bus.out_quotient, eq);
            check32("hold.remainder", bus.out_remainder, er);
            check1("hold.divzero", bus.out_divzero, 1'b0);
            bus.in_valid    = (i == 5);
            bus.in_dividend = 32'd77;
            bus.in_divisor  = 32'd0;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check1("hold.released_valid", bus.out_valid, 1'b0);
        check1("hold.released_ready", bus.in_ready, 1'b1);

        // Reset in the middle of iteration aborts the operation.
        bus.in_valid    = 1'b1;
        bus.in_dividend = 32'd123456;
        bus.in_divisor  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1("abort.out_valid", bus.out_valid, 1'b0);
        check1("abort.in_ready", bus.in_ready, 1'b1);
        check32("abort.quotient", bus.out_quotient, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 10 == 0) check1("abort.no_output", bus.out_valid, 1'b0);
        end
        run_op(32'd50, 32'd5, 1'b0, "post_abort");

`ifdef SIGNED_DIV_EN
        run_op(-32'sd7, 32'd2, 1'b1, "s_m7_2");
        run_op(32'd7, -32'sd2, 1'b1, "s_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        run_op(-32'sd9, 32'd0, 1'b1, "s_div0");
        run_op(-32'sd100, -32'sd7, 1'b1, "s_m100_m7");
`endif

        for (int i = 0; i < 24; i++) begin
            rn = $urandom;
            case ($urandom_range(0, 3))
                0:       rd = 32'($urandom_range(1, 16));
                1:       rd = $urandom >> $urandom_range(0, 31);
                2:       rd = (i % 6 == 0) ? 32'd0 : $urandom;
                default: rd = $urandom;
            endcase
`ifdef SIGNED_DIV_EN
            run_op(rn, rd, 1'($urandom_range(0, 1)), "rand");
`else
            run_op(rn, rd, 1'b0, "rand");
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
